// File: rtl/dcache_ctrl_if.sv
// Bundles the CPU-side request port and the backing-memory port of the data cache.
// The cache uses the slave modport; the CPU/memory environment uses master.
interface dcache_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output MemRead, MemWrite, addr, wdata, mem_ready, mem_rdata,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  MemRead, MemWrite, addr, wdata, mem_ready, mem_rdata,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// Load hits return data combinationally; misses and all stores stall the pipeline.
module dcache_ctrl #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, WR_DONE} state_t;

  state_t      state_q, state_d;
  logic [29:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [NUM_LINES-1:0] valid_vec;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [31:0]          data_arr [NUM_LINES];

  logic [IDX_W-1:0] in_idx, lat_idx;
  logic [TAG_W-1:0] in_tag, lat_tag;
  logic             in_hit, lat_hit;
  logic             fill_en, upd_en;
  logic             unused_addr_lsbs;

  logic        stall_c, mem_req_c, mem_we_c;
  logic [31:0] rdata_c, mem_addr_c, mem_wdata_c;

  assign in_idx  = bus.addr[IDX_W+1:2];
  assign in_tag  = bus.addr[31:IDX_W+2];
  assign lat_idx = waddr_q[IDX_W-1:0];
  assign lat_tag = waddr_q[29:IDX_W];
  assign in_hit  = valid_vec[in_idx] && (tag_arr[in_idx] == in_tag);
  assign lat_hit = valid_vec[lat_idx] && (tag_arr[lat_idx] == lat_tag);
  assign unused_addr_lsbs = ^bus.addr[1:0];

  // Line writes are gated by rst so a reset abandons any in-flight fill or store.
  assign fill_en = !rst && (state_q == RD_MISS) && bus.mem_ready;
  assign upd_en  = !rst && (state_q == WR_MEM) && bus.mem_ready && lat_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic             line_valid_q;
      logic [TAG_W-1:0] line_tag_q;
      logic [31:0]      line_data_q;
      logic             sel;

      assign sel = (lat_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          line_valid_q <= 1'b0;
        end else if (fill_en && sel) begin
          line_valid_q <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (fill_en && sel) begin
          line_tag_q  <= lat_tag;
          line_data_q <= bus.mem_rdata;
        end else if (upd_en && sel) begin
          line_data_q <= wdata_q;
        end
      end

      assign valid_vec[gi] = line_valid_q;
      assign tag_arr[gi]   = line_tag_q;
      assign data_arr[gi]  = line_data_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    stall_c     = 1'b0;
    rdata_c     = '0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    unique case (state_q)
      IDLE: begin
        // A store wins when both requests are high.
        if (bus.MemWrite) begin
          stall_c = 1'b1;
          waddr_d = bus.addr[31:2];
          wdata_d = bus.wdata;
          state_d = WR_MEM;
        end else if (bus.MemRead) begin
          if (in_hit) begin
            rdata_c = data_arr[in_idx];
          end else begin
            stall_c = 1'b1;
            waddr_d = bus.addr[31:2];
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {waddr_q, 2'b00};
        if (bus.mem_ready) state_d = IDLE;
      end
      WR_MEM: begin
        stall_c     = 1'b1;
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = {waddr_q, 2'b00};
        mem_wdata_c = wdata_q;
        if (bus.mem_ready) state_d = WR_DONE;
      end
      WR_DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      stall_c     = 1'b0;
      rdata_c     = '0;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.rdata     = rdata_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
endmodule
